// File: rtl/rotary_quad_decoder.sv
// rotary_quad_decoder
// Conditions the raw rotary encoder contacts (2-flop synchroniser, optional
// debounce) and decodes each detent into a one-cycle step pulse with a
// direction flag, plus a wrapping signed position count.
// Optional feature macro: ROT_DEBOUNCE_EN builds the per-contact debounce
// counters. Without it the filtered levels are the synchroniser outputs.
module rotary_quad_decoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int POS_W           = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rot_a,
    input  logic             rot_b,
    output logic             rot_event,
    output logic             rot_left,
    output logic             rot_err,
    output logic [POS_W-1:0] pos,
    output logic             a_clean,
    output logic             b_clean
);

    typedef enum logic [2:0] {
        DETENT   = 3'd0,
        A_LEAD   = 3'd1,
        B_LEAD   = 3'd2,
        ARMED    = 3'd3,
        WAIT_LOW = 3'd4
    } state_t;

    // Bit 1 carries contact A, bit 0 carries contact B throughout.
    logic [1:0]       meta_r;
    logic [1:0]       sync_r;
    logic [1:0]       clean_s;
    state_t           state_r;
    logic             rot_event_r;
    logic             rot_err_r;
    logic             rot_left_r;
    logic [POS_W-1:0] pos_r;

    // Reject illegal debounce lengths at elaboration time.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_cfg_check
        $error("rotary_quad_decoder: DEBOUNCE_CYCLES must be 2..65535");
    end

    // Two-flop synchroniser for both asynchronous contacts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_r <= 2'b00;
            sync_r <= 2'b00;
        end else begin
            meta_r <= {rot_a, rot_b};
            sync_r <= meta_r;
        end
    end

`ifdef ROT_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0] db_cnt_r [2];
    logic [1:0]  clean_r;

    // Per-contact run-length filter: the filtered level only follows the
    // synchronised level after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            db_cnt_r[0] <= 16'd0;
            db_cnt_r[1] <= 16'd0;
            clean_r     <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_r[i] == clean_r[i]) begin
                    db_cnt_r[i] <= 16'd0;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    clean_r[i]  <= sync_r[i];
                    db_cnt_r[i] <= 16'd0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + 16'd1;
                end
            end
        end
    end

    assign clean_s = clean_r;
`else
    assign clean_s = sync_r;
`endif

    // Detent decoder: a step is a clean single-contact lead followed by both
    // contacts high; diagonal jumps flag an error and park until 00.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= DETENT;
            rot_event_r <= 1'b0;
            rot_err_r   <= 1'b0;
            rot_left_r  <= 1'b0;
            pos_r       <= '0;
        end else begin
            rot_event_r <= 1'b0;
            rot_err_r   <= 1'b0;
            case (state_r)
                DETENT: begin
                    case (clean_s)
                        2'b10:   state_r <= A_LEAD;
                        2'b01:   state_r <= B_LEAD;
                        2'b11: begin
                            state_r   <= WAIT_LOW;
                            rot_err_r <= 1'b1;
                        end
                        default: state_r <= DETENT;
                    endcase
                end
                A_LEAD: begin
                    case (clean_s)
                        2'b11: begin
                            state_r     <= ARMED;
                            rot_event_r <= 1'b1;
                            rot_left_r  <= 1'b0;
                            pos_r       <= pos_r + POS_W'(1'b1);
                        end
                        2'b00:   state_r <= DETENT;
                        2'b01: begin
                            state_r   <= WAIT_LOW;
                            rot_err_r <= 1'b1;
                        end
                        default: state_r <= A_LEAD;
                    endcase
                end
                B_LEAD: begin
                    case (clean_s)
                        2'b11: begin
                            state_r     <= ARMED;
                            rot_event_r <= 1'b1;
                            rot_left_r  <= 1'b1;
                            pos_r       <= pos_r - POS_W'(1'b1);
                        end
                        2'b00:   state_r <= DETENT;
                        2'b10: begin
                            state_r   <= WAIT_LOW;
                            rot_err_r <= 1'b1;
                        end
                        default: state_r <= B_LEAD;
                    endcase
                end
                ARMED: begin
                    if (clean_s == 2'b00) begin
                        state_r <= DETENT;
                    end else begin
                        state_r <= ARMED;
                    end
                end
                WAIT_LOW: begin
                    if (clean_s == 2'b00) begin
                        state_r <= DETENT;
                    end else begin
                        state_r <= WAIT_LOW;
                    end
                end
                default: state_r <= DETENT;
            endcase
        end
    end

    assign rot_event = rot_event_r;
    assign rot_err   = rot_err_r;
    assign rot_left  = rot_left_r;
    assign pos       = pos_r;
    assign a_clean   = clean_s[1];
    assign b_clean   = clean_s[0];

endmodule
